// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues pipelined halfword fetches to a variable-latency memory
// and buffers {pc, instr} pairs in a credit-managed FIFO, dropping wrong-path responses.
module fetch_queue #(
  parameter int unsigned     WORD      = 32,
  parameter int unsigned     HALF_WORD = 16,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       stall_pipeline_i,
  input  logic                       redirect_valid_i,
  input  logic [WORD-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [WORD-1:0]            imem_addr_o,
  input  logic                       imem_valid_i,
  input  logic [HALF_WORD-1:0]       imem_instr_i,
  output logic                       instr_valid_o,
  output logic [HALF_WORD-1:0]       instruction_o,
  output logic [WORD-1:0]            program_counter_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned CntW = $clog2(2 * DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WORD-1:0]      fetch_pc_q, fetch_pc_d;
  logic [WORD-1:0]      resp_pc_q, resp_pc_d;
  logic [CntW-1:0]      out_cnt_q, out_cnt_d;
  logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [WORD-1:0]      pc_mem_q    [DEPTH];
  logic [HALF_WORD-1:0] instr_mem_q [DEPTH];

  logic [SumW-1:0] in_use;
  logic            issue;
  logic            push;
  logic            pop;
  logic [WORD-1:0] redirect_pc_aligned;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Live credits: buffered entries plus in-flight requests that will actually be pushed.
  assign in_use = SumW'(occ_q) + SumW'(out_cnt_q - drop_cnt_q);
  assign issue  = reset_i && !redirect_valid_i && (in_use < SumW'(DEPTH));
  assign push   = imem_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
  assign pop    = (occ_q != '0) && !stall_pipeline_i && !redirect_valid_i;

  assign redirect_pc_aligned = redirect_pc_i & ~WORD'(1);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CntW'(issue) - CntW'(imem_valid_i);
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      // A response arriving now is discarded here, so it does not occupy a drop slot.
      drop_cnt_d = out_cnt_q - CntW'(imem_valid_i);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + WORD'(2);
      if (push) begin
        resp_pc_d = resp_pc_q + WORD'(2);
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        occ_d = occ_q + OccW'(1);
      end else if (pop && !push) begin
        occ_d = occ_q - OccW'(1);
      end
      if (imem_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr_i;
    end
  end

  assign imem_req_o        = issue;
  assign imem_addr_o       = reset_i ? fetch_pc_q : '0;
  assign instr_valid_o     = (occ_q != '0);
  assign instruction_o     = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign program_counter_o = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign occupancy_o       = occ_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order variable-latency memory model plus a queue-based
// reference of outstanding requests and buffered instructions, checked every cycle.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, stall, redir, imem_valid;
  logic [31:0] redir_pc;
  logic [15:0] imem_instr;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc;
  logic [15:0] instr;
  logic [2:0]  occ;

  always #5 clk = ~clk;

  fetch_queue #(.WORD(32), .HALF_WORD(16), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .reset_i(reset_n), .stall_pipeline_i(stall), .redirect_valid_i(redir),
    .redirect_pc_i(redir_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_valid_i(imem_valid), .imem_instr_i(imem_instr), .instr_valid_o(instr_valid),
    .instruction_o(instr), .program_counter_o(pc), .occupancy_o(occ)
  );

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] addr; bit live;} oreq_t;
  typedef struct {logic [31:0] pc; logic [15:0] instr;} ent_t;

  mreq_t       mq[$];
  oreq_t       oq[$];
  ent_t        mf[$];
  logic [31:0] mpc;
  int          n_tests = 0, n_fail = 0, cyc = 0, lat = 1;
  bit          seen;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    return {a[8:1], a[16:9]} ^ 16'hC35A ^ a[31:16];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cycle();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_instr = mem_f(mq[0].addr);
    end else begin
      imem_valid = 1'b0;
      imem_instr = 16'h0;
    end
    #1;
  endtask

  task automatic finish_cycle();
    int live = 0, drops = 0;
    bit exp_req, v, rd, st, r_req;
    logic [31:0] rpc, r_addr;
    foreach (oq[i]) if (oq[i].live) live++; else drops++;
    exp_req = !redir && (mf.size() + live < DEPTH);
    chk("req", imem_req, exp_req);
    chk("addr", imem_addr, mpc);
    chk("valid", instr_valid, mf.size() > 0);
    chk("instr", instr, mf.size() > 0 ? mf[0].instr : 16'h0);
    chk("pc", pc, mf.size() > 0 ? mf[0].pc : 32'h0);
    chk("occ", occ, mf.size());
    chk("out_cnt", dut.out_cnt_q, oq.size());
    chk("drop_cnt", dut.drop_cnt_q, drops);
    chk("invariant", (dut.drop_cnt_q <= dut.out_cnt_q) && (dut.out_cnt_q <= 2 * DEPTH), 1);
    v = imem_valid; rd = redir; st = stall; rpc = redir_pc; r_req = imem_req; r_addr = imem_addr;
    @(posedge clk);
    cyc++;
    if (v) void'(mq.pop_front());
    if (r_req) mq.push_back('{r_addr, cyc - 1 + lat});
    if (!rd && mf.size() > 0 && !st) void'(mf.pop_front());
    if (v) begin
      if (oq.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        oreq_t e;
        e = oq.pop_front();
        if (!rd && e.live) mf.push_back('{e.addr, mem_f(e.addr)});
      end
    end
    if (rd) begin
      mf.delete();
      foreach (oq[i]) oq[i].live = 1'b0;
      mpc = rpc & ~32'h1;
    end else if (exp_req) begin
      oq.push_back('{mpc, 1'b1});
      mpc += 32'd2;
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_cycle();
      finish_cycle();
    end
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    reset_n = 1'b0; imem_valid = 1'b0; imem_instr = 16'h0; redir = 1'b0; stall = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_occ", occ, 0);
    mq.delete(); oq.delete(); mf.delete(); mpc = 32'h0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    imem_valid = 1'b0; imem_instr = 16'h0; mpc = 32'h0;
    @(posedge clk); #1;
    do_reset();

    // Streaming with 1-cycle memory
    drive_cycle(); chk("t1_addr0", imem_addr, 32'h0); chk("t1_req0", imem_req, 1); finish_cycle();
    drive_cycle(); chk("t1_addr2", imem_addr, 32'h2); chk("t1_valid1", instr_valid, 0); finish_cycle();
    drive_cycle(); chk("t1_valid2", instr_valid, 1); chk("t1_pc0", pc, 32'h0);
    chk("t1_addr4", imem_addr, 32'h4); finish_cycle();
    drive_cycle(); chk("t1_pc2", pc, 32'h2); finish_cycle();
    run(5);

    // Stall until credits run out, then drain
    stall = 1'b1;
    run(10);
    drive_cycle(); chk("t2_occ4", occ, 4); chk("t2_req0", imem_req, 0); finish_cycle();
    stall = 1'b0;
    run(8);

    // Misaligned redirect target and PC wrap
    redir = 1'b1; redir_pc = 32'h101;
    drive_cycle(); chk("t6_req_redir", imem_req, 0); finish_cycle();
    redir = 1'b0;
    drive_cycle(); chk("t6_addr100", imem_addr, 32'h100); finish_cycle();
    run(3);
    redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
    drive_cycle(); finish_cycle();
    redir = 1'b0;
    drive_cycle(); chk("t6_addr_top", imem_addr, 32'hFFFF_FFFE); chk("t6_req", imem_req, 1);
    finish_cycle();
    drive_cycle(); chk("t6_wrap", imem_addr, 32'h0); finish_cycle();
    run(4);

    // 3-cycle memory, redirect with two requests in flight
    do_reset();
    lat = 3;
    run(2);
    redir = 1'b1; redir_pc = 32'h100;
    drive_cycle(); chk("t3_out2", dut.out_cnt_q, 2); finish_cycle();
    redir = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_cycle();
      if (instr_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", pc, 32'h100);
        chk("t3_first_instr", instr, 16'h435A);
      end
      finish_cycle();
    end
    if (!seen) chk("t3_timeout", 0, 1);
    run(6);

    // Redirect coinciding with a response and a would-be pop
    do_reset();
    lat = 2;
    run(6);
    redir = 1'b1; redir_pc = 32'h40;
    drive_cycle(); chk("t4_head_valid", instr_valid, 1); chk("t4_out2", dut.out_cnt_q, 2);
    finish_cycle();
    redir = 1'b0;
    drive_cycle(); chk("t4_occ0", occ, 0); chk("t4_out1", dut.out_cnt_q, 1);
    chk("t4_drop1", dut.drop_cnt_q, 1); finish_cycle();
    run(8);

    // Asynchronous reset mid-stream, with some stall activity afterwards
    do_reset();
    drive_cycle(); chk("t5_addr0", imem_addr, 32'h0); chk("t5_req", imem_req, 1); finish_cycle();
    run(4);
    stall = 1'b1; run(3);
    stall = 1'b0; run(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
